// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if
//   Bundles the game-stream signals between the pipe generator / bird
//   controller side (master) and the pipe_scroller consumer (slave).
//   Ports:
//     active    master->slave  game-running enable
//     col_in    master->slave  8-bit column pattern, bit r = pipe LED at row r
//     bird_row  master->slave  one-hot bird row, zero = off-screen
//     frame     slave->master  8*COLS frame buffer, column c = frame[8c+7:8c]
//     step      slave->master  one-cycle scroll pulse
//     gameover  slave->master  sticky crash flag
//     score     slave->master  saturating pipes-cleared counter
interface pipe_scroller_if #(
    parameter int COLS    = 16,
    parameter int SCORE_W = 8
);
    logic                 active;
    logic [7:0]           col_in;
    logic [7:0]           bird_row;
    logic [8*COLS-1:0]    frame;
    logic                 step;
    logic                 gameover;
    logic [SCORE_W-1:0]   score;

    modport master (
        output active, col_in, bird_row,
        input  frame, step, gameover, score
    );

    modport slave (
        input  active, col_in, bird_row,
        output frame, step, gameover, score
    );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller
//   Consumer side of the pipe column stream. Every SHIFT_DIV clocks in RUN
//   the frame scrolls one column left and col_in enters at column COLS-1.
//   The bird's row is tested against column BIRD_COL every RUN cycle; a hit
//   (or an off-screen bird) latches gameover and freezes the frame. Pipes
//   leaving the bird column are counted in a saturating score.
//   Ports:
//     clk    system clock
//     reset  asynchronous active-high reset, clears all state
//     bus    pipe_scroller_if slave modport (inputs active/col_in/bird_row,
//            registered outputs frame/step/gameover/score)
module pipe_scroller #(
    parameter int COLS      = 16,
    parameter int SHIFT_DIV = 512,
    parameter int BIRD_COL  = 2,
    parameter int SCORE_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    pipe_scroller_if.slave  bus
);

    localparam int DIV_W = $clog2(SHIFT_DIV);
    localparam int FW    = 8 * COLS;

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t               state_q, state_d;
    logic [FW-1:0]        frame_q, frame_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 step_q, step_d;
    logic                 gameover_q, gameover_d;

    logic [7:0]           bird_col_bits;
    logic                 crash;
    logic                 div_wrap;

    // Crash uses the registered frame, so a column arriving at BIRD_COL is
    // tested from the cycle after the scroll edge that placed it there.
    assign bird_col_bits = frame_q[8*BIRD_COL +: 8];
    assign crash         = ((bird_col_bits & bus.bird_row) != 8'h00) ||
                           (bus.bird_row == 8'h00);
    assign div_wrap      = (div_q == DIV_W'(SHIFT_DIV - 1));

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        div_d      = div_q;
        score_d    = score_q;
        step_d     = 1'b0;
        gameover_d = gameover_q;

        unique case (state_q)
            IDLE: begin
                frame_d    = '0;
                score_d    = '0;
                div_d      = '0;
                gameover_d = 1'b0;
                if (bus.active) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (!bus.active) begin
                    state_d    = IDLE;
                    frame_d    = '0;
                    score_d    = '0;
                    div_d      = '0;
                    gameover_d = 1'b0;
                end else if (crash) begin
                    // Crash wins over a coincident scroll: frame, score and
                    // divider stay as they are.
                    state_d    = OVER;
                    gameover_d = 1'b1;
                end else if (div_wrap) begin
                    div_d   = '0;
                    step_d  = 1'b1;
                    frame_d = {bus.col_in, frame_q[FW-1:8]};
                    if ((bird_col_bits != 8'h00) && (score_q != '1)) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            OVER: begin
                if (!bus.active) begin
                    state_d    = IDLE;
                    frame_d    = '0;
                    score_d    = '0;
                    div_d      = '0;
                    gameover_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            div_q      <= '0;
            score_q    <= '0;
            step_q     <= 1'b0;
            gameover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            div_q      <= div_d;
            score_q    <= score_d;
            step_q     <= step_d;
            gameover_q <= gameover_d;
        end
    end

    assign bus.frame    = frame_q;
    assign bus.step     = step_q;
    assign bus.gameover = gameover_q;
    assign bus.score    = score_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller
//   Self-checking bench for pipe_scroller. Two instances share one stimulus
//   stream: dut (SCORE_W=8) and dut2 (SCORE_W=2, for saturation). A
//   queue-based reference model counts RUN cycles and scrolls a queue of
//   column bytes; each test task compares DUT outputs against it.
module tb_pipe_scroller;

    localparam int COLS      = 16;
    localparam int SHIFT_DIV = 4;
    localparam int BIRD_COL  = 2;
    localparam int SCORE_W   = 8;
    localparam int SMAX1     = (1 << SCORE_W) - 1;
    localparam int SMAX2     = 3;

    logic clk;
    logic reset;

    pipe_scroller_if #(.COLS(COLS), .SCORE_W(SCORE_W)) if1 ();
    pipe_scroller_if #(.COLS(COLS), .SCORE_W(2))       if2 ();

    assign if2.active   = if1.active;
    assign if2.col_in   = if1.col_in;
    assign if2.bird_row = if1.bird_row;

    pipe_scroller #(
        .COLS(COLS), .SHIFT_DIV(SHIFT_DIV), .BIRD_COL(BIRD_COL), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(if1)
    );

    pipe_scroller #(
        .COLS(COLS), .SHIFT_DIV(SHIFT_DIV), .BIRD_COL(BIRD_COL), .SCORE_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: 0 idle, 1 running, 2 crashed.
    int         m_state;
    int         m_runcyc;
    logic [7:0] m_cols[$];
    int         m_score;
    int         m_score2;
    logic       m_go;
    logic       m_step;

    task automatic model_clear();
        m_state  = 0;
        m_runcyc = 0;
        m_cols   = {};
        for (int c = 0; c < COLS; c++) m_cols.push_back(8'h00);
        m_score  = 0;
        m_score2 = 0;
        m_go     = 1'b0;
        m_step   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_update();
        bit hit;
        m_step = 1'b0;
        case (m_state)
            0: if (if1.active) begin
                m_state  = 1;
                m_runcyc = 0;
            end
            1: begin
                if (!if1.active) begin
                    model_clear();
                end else begin
                    hit = ((m_cols[BIRD_COL] & if1.bird_row) != 0) || (if1.bird_row == 0);
                    if (hit) begin
                        m_state = 2;
                        m_go    = 1'b1;
                    end else begin
                        m_runcyc++;
                        if (m_runcyc % SHIFT_DIV == 0) begin
                            m_step = 1'b1;
                            if (m_cols[BIRD_COL] != 0) begin
                                if (m_score < SMAX1) m_score++;
                                if (m_score2 < SMAX2) m_score2++;
                            end
                            void'(m_cols.pop_front());
                            m_cols.push_back(if1.col_in);
                        end
                    end
                end
            end
            default: if (!if1.active) model_clear();
        endcase
    endtask

    function automatic logic [8*COLS-1:0] exp_frame();
        logic [8*COLS-1:0] f;
        for (int c = 0; c < COLS; c++) f[8*c +: 8] = m_cols[c];
        return f;
    endfunction

    function automatic logic [7:0] col_of(input logic [8*COLS-1:0] f, input int c);
        return f[8*c +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic apply_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        if1.active   = 1'b0;
        if1.col_in   = 8'h00;
        if1.bird_row = 8'h10;
        model_clear();
        #2;
        total_cnt++; if (if1.frame !== '0) $display("FAIL reset_frame got=%h exp=0", if1.frame); else pass_cnt++;
        total_cnt++; if (if1.step !== 1'b0) $display("FAIL reset_step got=%b exp=0", if1.step); else pass_cnt++;
        total_cnt++; if (if1.gameover !== 1'b0) $display("FAIL reset_gameover got=%b exp=0", if1.gameover); else pass_cnt++;
        total_cnt++; if (if1.score !== '0) $display("FAIL reset_score got=%0d exp=0", if1.score); else pass_cnt++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (if1.frame !== exp_frame()) $display("FAIL idle_frame got=%h exp=%h", if1.frame, exp_frame()); else pass_cnt++;
            total_cnt++; if (if1.step !== m_step) $display("FAIL idle_step got=%b exp=%b", if1.step, m_step); else pass_cnt++;
        end
    endtask

    task automatic test_scroll();
        apply_reset();
        if1.bird_row = 8'b0001_0000;
        if1.col_in   = 8'hE7;
        if1.active   = 1'b1;
        tick();
        for (int i = 1; i <= 64; i++) begin
            if1.col_in = (i <= SHIFT_DIV) ? 8'hE7 : 8'h00;
            tick();
            total_cnt++; if (if1.frame !== exp_frame()) $display("FAIL scroll_frame edge=%0d got=%h exp=%h", i, if1.frame, exp_frame()); else pass_cnt++;
            total_cnt++; if (if1.step !== ((i % SHIFT_DIV) == 0)) $display("FAIL scroll_step edge=%0d got=%b exp=%b", i, if1.step, (i % SHIFT_DIV) == 0); else pass_cnt++;
            total_cnt++; if (if1.gameover !== 1'b0) $display("FAIL scroll_gameover edge=%0d got=%b exp=0", i, if1.gameover); else pass_cnt++;
            total_cnt++; if (if1.score !== SCORE_W'(m_score)) $display("FAIL scroll_score edge=%0d got=%0d exp=%0d", i, if1.score, m_score); else pass_cnt++;
            if (i == 4) begin
                total_cnt++; if (col_of(if1.frame, COLS-1) !== 8'hE7) $display("FAIL scroll_col15_step1 got=%h exp=e7", col_of(if1.frame, COLS-1)); else pass_cnt++;
            end
            if (i == 56) begin
                total_cnt++; if (col_of(if1.frame, BIRD_COL) !== 8'hE7) $display("FAIL scroll_col2_step14 got=%h exp=e7", col_of(if1.frame, BIRD_COL)); else pass_cnt++;
                total_cnt++; if (if1.score !== 8'd0) $display("FAIL scroll_score_step14 got=%0d exp=0", if1.score); else pass_cnt++;
            end
            if (i == 60) begin
                total_cnt++; if (if1.score !== 8'd1) $display("FAIL scroll_score_step15 got=%0d exp=1", if1.score); else pass_cnt++;
            end
        end
    endtask

    task automatic test_collision();
        apply_reset();
        if1.bird_row = 8'b0000_0001;
        if1.col_in   = 8'hE7;
        if1.active   = 1'b1;
        tick();
        for (int i = 1; i <= 68; i++) begin
            if1.col_in = (i <= SHIFT_DIV) ? 8'hE7 : 8'h00;
            tick();
            total_cnt++; if (if1.frame !== exp_frame()) $display("FAIL coll_frame edge=%0d got=%h exp=%h", i, if1.frame, exp_frame()); else pass_cnt++;
            total_cnt++; if (if1.step !== m_step) $display("FAIL coll_step edge=%0d got=%b exp=%b", i, if1.step, m_step); else pass_cnt++;
            total_cnt++; if (if1.gameover !== m_go) $display("FAIL coll_gameover edge=%0d got=%b exp=%b", i, if1.gameover, m_go); else pass_cnt++;
            if (i == 56) begin
                total_cnt++; if (if1.gameover !== 1'b0) $display("FAIL coll_go_before got=%b exp=0", if1.gameover); else pass_cnt++;
            end
            if (i == 57) begin
                total_cnt++; if (if1.gameover !== 1'b1) $display("FAIL coll_go_after got=%b exp=1", if1.gameover); else pass_cnt++;
            end
            if (i > 57) begin
                total_cnt++; if (if1.step !== 1'b0) $display("FAIL coll_no_step edge=%0d got=%b exp=0", i, if1.step); else pass_cnt++;
            end
        end
        total_cnt++; if (col_of(if1.frame, BIRD_COL) !== 8'hE7) $display("FAIL coll_frozen_col2 got=%h exp=e7", col_of(if1.frame, BIRD_COL)); else pass_cnt++;
        total_cnt++; if (if1.score !== 8'd0) $display("FAIL coll_score got=%0d exp=0", if1.score); else pass_cnt++;
    endtask

    // Continues from the crashed state left by test_collision.
    task automatic test_restart();
        if1.bird_row = 8'b0001_0000;
        if1.col_in   = 8'h00;
        if1.active   = 1'b0;
        tick();
        total_cnt++; if (if1.gameover !== 1'b0) $display("FAIL restart_go got=%b exp=0", if1.gameover); else pass_cnt++;
        total_cnt++; if (if1.score !== 8'd0) $display("FAIL restart_score got=%0d exp=0", if1.score); else pass_cnt++;
        total_cnt++; if (if1.frame !== '0) $display("FAIL restart_frame got=%h exp=0", if1.frame); else pass_cnt++;
        if1.active = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            tick();
            total_cnt++; if (if1.step !== ((i % SHIFT_DIV) == 0)) $display("FAIL restart_step edge=%0d got=%b exp=%b", i, if1.step, (i % SHIFT_DIV) == 0); else pass_cnt++;
            total_cnt++; if (if1.frame !== exp_frame()) $display("FAIL restart_frame_run edge=%0d got=%h exp=%h", i, if1.frame, exp_frame()); else pass_cnt++;
        end
    endtask

    task automatic test_offscreen();
        apply_reset();
        if1.bird_row = 8'b0001_0000;
        if1.col_in   = 8'h00;
        if1.active   = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        total_cnt++; if (if1.gameover !== 1'b0) $display("FAIL offscr_before got=%b exp=0", if1.gameover); else pass_cnt++;
        if1.bird_row = 8'h00;
        tick();
        total_cnt++; if (if1.gameover !== 1'b1) $display("FAIL offscr_go got=%b exp=1", if1.gameover); else pass_cnt++;
        total_cnt++; if (if1.gameover !== m_go) $display("FAIL offscr_model got=%b exp=%b", if1.gameover, m_go); else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [7:0] pipes[5];
        for (int k = 0; k < 5; k++) begin
            pipes[k] = 8'($urandom_range(1, 255)) & 8'hEF;
            if (pipes[k] == 8'h00) pipes[k] = 8'h01;
        end
        apply_reset();
        if1.bird_row = 8'b0001_0000;
        if1.col_in   = pipes[0];
        if1.active   = 1'b1;
        tick();
        for (int i = 1; i <= 26 * SHIFT_DIV; i++) begin
            int s;
            s = (i + SHIFT_DIV - 1) / SHIFT_DIV;
            if1.col_in = ((s % 2 == 1) && (s <= 9)) ? pipes[(s - 1) / 2] : 8'h00;
            tick();
            total_cnt++; if (if1.frame !== exp_frame()) $display("FAIL sat_frame edge=%0d got=%h exp=%h", i, if1.frame, exp_frame()); else pass_cnt++;
            total_cnt++; if (if1.score !== SCORE_W'(m_score)) $display("FAIL sat_score8 edge=%0d got=%0d exp=%0d", i, if1.score, m_score); else pass_cnt++;
            total_cnt++; if (if2.score !== 2'(m_score2)) $display("FAIL sat_score2 edge=%0d got=%0d exp=%0d", i, if2.score, m_score2); else pass_cnt++;
            for (int k = 1; k <= 5; k++) begin
                if (i == SHIFT_DIV * (2 * k + 14)) begin
                    total_cnt++; if (if2.score !== 2'((k < 3) ? k : 3)) $display("FAIL sat_seq pipe=%0d got=%0d exp=%0d", k, if2.score, (k < 3) ? k : 3); else pass_cnt++;
                    total_cnt++; if (if1.score !== 8'(k)) $display("FAIL sat_wide pipe=%0d got=%0d exp=%0d", k, if1.score, k); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        if1.bird_row = 8'b0001_0000;
        if1.active   = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if1.col_in = 8'($urandom_range(1, 255)) | 8'h01;
            tick();
        end
        total_cnt++; if (if1.frame !== exp_frame()) $display("FAIL arst_pre_frame got=%h exp=%h", if1.frame, exp_frame()); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if (if1.frame !== '0) $display("FAIL arst_frame got=%h exp=0", if1.frame); else pass_cnt++;
        total_cnt++; if (if1.score !== '0) $display("FAIL arst_score got=%0d exp=0", if1.score); else pass_cnt++;
        total_cnt++; if (if1.step !== 1'b0) $display("FAIL arst_step got=%b exp=0", if1.step); else pass_cnt++;
        total_cnt++; if (if1.gameover !== 1'b0) $display("FAIL arst_go got=%b exp=0", if1.gameover); else pass_cnt++;
        if1.active = 1'b0;
        #1;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (if1.frame !== '0) $display("FAIL arst_idle_frame got=%h exp=0", if1.frame); else pass_cnt++;
            total_cnt++; if (if1.step !== 1'b0) $display("FAIL arst_idle_step got=%b exp=0", if1.step); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        if1.bird_row = 8'h01 << $urandom_range(0, 7);
        for (int i = 0; i < 600; i++) begin
            if1.active = ($urandom_range(0, 99) < 93);
            if1.col_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                if1.bird_row = ($urandom_range(0, 29) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            end
            tick();
            total_cnt++; if (if1.frame !== exp_frame()) $display("FAIL rnd_frame cyc=%0d got=%h exp=%h", i, if1.frame, exp_frame()); else pass_cnt++;
            total_cnt++; if (if1.step !== m_step) $display("FAIL rnd_step cyc=%0d got=%b exp=%b", i, if1.step, m_step); else pass_cnt++;
            total_cnt++; if (if1.gameover !== m_go) $display("FAIL rnd_go cyc=%0d got=%b exp=%b", i, if1.gameover, m_go); else pass_cnt++;
            total_cnt++; if (if1.score !== SCORE_W'(m_score)) $display("FAIL rnd_score cyc=%0d got=%0d exp=%0d", i, if1.score, m_score); else pass_cnt++;
            total_cnt++; if (if2.score !== 2'(m_score2)) $display("FAIL rnd_score2 cyc=%0d got=%0d exp=%0d", i, if2.score, m_score2); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_collision();
        test_restart();
        test_offscreen();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
